spi_master_cfg: RTL and testbench
=================================

# spi_master_cfg

Parametrised SPI master that replaces the fixed 8-bit, single-slave, CPOL=1/CPHA=0 driver. Word width and slave count are set at elaboration. SPI mode, bit order, SCLK divider and slave select are latched per transfer. A start/ready handshake and a single-cycle done strobe connect it to a register-file or DMA front end, and it drives one active-low chip select per slave.

## Interface
- DATA_W, 8: bits per transfer, ≥2.
- NUM_CS, 4: number of chip-select outputs, ≥1; CS_W = max(1, $clog2(NUM_CS)).
- DIV_W, 8: width of the clock-divider input.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  transfer request; accepted when start && ready.
- ready  out  1  high in IDLE; low while a transfer is in progress.
- data_in  in  DATA_W  transmit word, latched on accept.
- cs_sel  in  CS_W  slave index, latched on accept.
- cpol  in  1  SCLK idle level, latched on accept.
- cpha  in  1  0 = sample on the leading edge; 1 = sample on the trailing edge. Latched on accept.
- lsb_first  in  1  1 = LSB first, else MSB first. Latched on accept.
- clk_div  in  DIV_W  SCLK half-period H = clk_div+1 clk cycles. Latched on accept.
- done  out  1  one-cycle strobe when a transfer completes.
- data_out  out  DATA_W  received word; updated only in the done cycle, held otherwise.
- spi_sclk  out  1  serial clock, registered.
- spi_mosi  out  1  serial data out, registered.
- spi_miso  in  1  serial data in.
- spi_cs_n  out  NUM_CS  active-low chip selects, registered.

## Operation
- States:
  - IDLE → ACTIVE on start && ready.
  - ACTIVE → TRAIL after edge 2·DATA_W.
  - TRAIL → IDLE after H cycles.
- Accept: latch data_in into the TX shift register, plus the cfg inputs, and clear the RX shift register. Config inputs are ignored at every other time.
- ACTIVE: a half-period counter runs 0..H-1. Each wrap toggles spi_sclk and increments the edge counter (width $clog2(2·DATA_W)+1).
  - Odd edges are leading edges; even edges are trailing edges.
- CPHA=0:
  - First TX bit is on spi_mosi from the first ACTIVE cycle.
  - spi_miso is sampled into RX on each leading edge.
  - TX shifts on each trailing edge except the last.
- CPHA=1:
  - TX bit driven on each leading edge.
  - spi_miso sampled on each trailing edge.
  - Before the first leading edge, spi_mosi holds the first TX bit.
- Bit order:
  - lsb_first=0: TX is sent from bit DATA_W-1 downward; RX fills from the LSB side, shifting left.
  - lsb_first=1: TX is sent from bit 0 upward; RX fills from the MSB side, shifting right.
  - In both cases data_out equals the slave word with its native bit significance.
- spi_cs_n[cs_sel] is low from the first ACTIVE cycle through the last TRAIL cycle. All other chip selects stay high.
- cs_sel ≥ NUM_CS: the transfer runs normally with all spi_cs_n high, and done still pulses.
- IDLE outputs:
  - spi_sclk = cpol input registered every cycle.
  - spi_mosi = 0.
  - spi_cs_n = all ones.

## Timing
- Reset values:
  - ready=1, done=0, data_out=0.
  - spi_sclk=0, spi_mosi=0, spi_cs_n all ones.
  - Internal counters 0, state IDLE.
- Accept in cycle T. In cycle T+1: ready=0, CS low, spi_sclk=latched cpol.
- Edge k (k = 1..2·DATA_W) appears on spi_sclk in cycle T+1+k·H.
- MISO is sampled by the clk edge that produces a sampling SCLK edge. The slave must therefore present data ≥1 clk cycle before that SCLK edge.
- In cycle D = T+1+(2·DATA_W+1)·H:
  - CS goes high, done=1, data_out updates, ready=1.
  - Total CS-low time is (2·DATA_W+1)·H cycles.
- Back-to-back: a start in cycle D is accepted, so CS is high for exactly one cycle (D) between transfers.
- A start while ready=0 is ignored; it is neither queued nor flagged.
- Reset asserted mid-transfer: all outputs take their reset values immediately, the transfer is abandoned, done is not pulsed and data_out is cleared.
- clk_div=0 gives H=1, so spi_sclk = clk/2. Maximum H is 2^DIV_W.

## Test plan
- Mode 0, DATA_W=8, clk_div=0, data_in=0xA5, MISO looped back from MOSI, accept at T:
  - CS low at T+1, done at T+18, data_out=0xA5.
  - Exactly 16 SCLK toggles, idle low.
- Mode 3 (cpol=1, cpha=1), clk_div=3, data_in=0x3C, slave model returns 0xC3:
  - SCLK idles high and half-period is 4 cycles.
  - MOSI changes only on falling edges.
  - done at T+1+17·4, data_out=0xC3.
- lsb_first=1, mode 1, data_in=0x01, slave returns 0x80:
  - MOSI is 1 only in the first bit slot.
  - data_out=0x80.
- Back-to-back: start held high across two transfers with cs_sel=2 then 0:
  - spi_cs_n[2] low, then one cycle of all-high, then spi_cs_n[0] low.
  - Exactly two done pulses.
  - A start asserted mid-transfer has no effect.
- Reset at edge 5 of a transfer:
  - Same cycle: spi_cs_n=all ones, ready=1, data_out=0, no done.
  - The next transfer after reset completes correctly.
- cs_sel=NUM_CS (out of range), NUM_CS=3:
  - All CS stay high, SCLK still toggles 2·DATA_W times, done pulses once.

Source files
------------

// File: rtl/spi_master_cfg.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_cfg
// Brief    : SPI master with elaboration-time word width and slave count.
//            Mode, bit order, divider and slave select are latched per transfer.
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_cfg #(
    parameter int DATA_W = 8,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 8,
    parameter int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              ready,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CS_W-1:0]   cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [DIV_W-1:0]  clk_div,
    output logic              done,
    output logic [DATA_W-1:0] data_out,
    output logic              spi_sclk,
    output logic              spi_mosi,
    input  logic              spi_miso,
    output logic [NUM_CS-1:0] spi_cs_n
);

    localparam int c_EDGE_W = $clog2(2 * DATA_W) + 1;
    localparam logic [c_EDGE_W-1:0] c_LAST_EDGE = c_EDGE_W'(2 * DATA_W - 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACTIVE = 2'd1;
    localparam logic [1:0] c_TRAIL  = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;

    logic [DIV_W-1:0]    r_cnt;
    logic [DIV_W-1:0]    r_div;
    logic [c_EDGE_W-1:0] r_edge;
    logic [DATA_W-1:0]   r_tx;
    logic [DATA_W-1:0]   r_rx;
    logic                r_cpha;
    logic                r_lsb;
    logic                r_done;
    logic [DATA_W-1:0]   r_data_out;
    logic                r_sclk;
    logic                r_mosi;
    logic [NUM_CS-1:0]   r_cs_n;

    logic                w_wrap;
    logic                w_last_edge;
    logic                w_leading;
    logic                w_sample;
    logic                w_shift;
    logic [DATA_W-1:0]   w_rx_next;
    logic [DATA_W-1:0]   w_tx_next;
    logic                w_mosi_next;
    logic [NUM_CS-1:0]   w_cs_dec;

    // An out-of-range index matches no bit, so every select stays high.
    for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
        assign w_cs_dec[gi] = (cs_sel != CS_W'(gi));
    end

    assign w_wrap      = (r_cnt == r_div);
    assign w_last_edge = (r_edge == c_LAST_EDGE);
    // r_edge holds edges already produced; the next one is odd (leading) when it is even.
    assign w_leading   = ~r_edge[0];
    assign w_sample    = (w_leading != r_cpha);
    assign w_shift     = r_cpha ? (w_leading && (r_edge != '0))
                                : (!w_leading && !w_last_edge);

    assign w_rx_next   = r_lsb ? {spi_miso, r_rx[DATA_W-1:1]}
                               : {r_rx[DATA_W-2:0], spi_miso};
    assign w_tx_next   = r_lsb ? (r_tx >> 1) : (r_tx << 1);
    assign w_mosi_next = r_lsb ? r_tx[1] : r_tx[DATA_W-2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_state_next = c_ACTIVE;
                end
            end
            c_ACTIVE: begin
                if (w_wrap && w_last_edge) begin
                    w_state_next = c_TRAIL;
                end
            end
            c_TRAIL: begin
                if (w_wrap) begin
                    w_state_next = c_IDLE;
                end
            end
            default: begin
                w_state_next = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_div      <= '0;
            r_edge     <= '0;
            r_tx       <= '0;
            r_rx       <= '0;
            r_cpha     <= 1'b0;
            r_lsb      <= 1'b0;
            r_done     <= 1'b0;
            r_data_out <= '0;
            r_sclk     <= 1'b0;
            r_mosi     <= 1'b0;
            r_cs_n     <= '1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    r_sclk <= cpol;
                    r_mosi <= 1'b0;
                    r_cs_n <= '1;
                    r_cnt  <= '0;
                    r_edge <= '0;
                    if (start) begin
                        r_tx   <= data_in;
                        r_rx   <= '0;
                        r_cpha <= cpha;
                        r_lsb  <= lsb_first;
                        r_div  <= clk_div;
                        r_mosi <= lsb_first ? data_in[0] : data_in[DATA_W-1];
                        r_cs_n <= w_cs_dec;
                    end
                end
                c_ACTIVE: begin
                    if (w_wrap) begin
                        r_cnt  <= '0;
                        r_sclk <= ~r_sclk;
                        r_edge <= r_edge + c_EDGE_W'(1);
                        if (w_sample) begin
                            r_rx <= w_rx_next;
                        end
                        if (w_shift) begin
                            r_tx   <= w_tx_next;
                            r_mosi <= w_mosi_next;
                        end
                    end else begin
                        r_cnt <= r_cnt + DIV_W'(1);
                    end
                end
                c_TRAIL: begin
                    if (w_wrap) begin
                        r_cnt      <= '0;
                        r_done     <= 1'b1;
                        r_data_out <= r_rx;
                        r_cs_n     <= '1;
                        r_mosi     <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign ready    = (r_state == c_IDLE);
    assign done     = r_done;
    assign data_out = r_data_out;
    assign spi_sclk = r_sclk;
    assign spi_mosi = r_mosi;
    assign spi_cs_n = r_cs_n;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_cfg.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_master_cfg
// Brief    : Directed scoreboard bench for spi_master_cfg (DATA_W=8, NUM_CS=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_master_cfg;

    localparam int DATA_W = 8;
    localparam int NUM_CS = 3;
    localparam int DIV_W  = 8;
    localparam int CS_W   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              ready;
    logic [DATA_W-1:0] data_in;
    logic [CS_W-1:0]   cs_sel;
    logic              cpol;
    logic              cpha;
    logic              lsb_first;
    logic [DIV_W-1:0]  clk_div;
    logic              done;
    logic [DATA_W-1:0] data_out;
    logic              spi_sclk;
    logic              spi_mosi;
    logic              spi_miso;
    logic [NUM_CS-1:0] spi_cs_n;

    spi_master_cfg #(
        .DATA_W (DATA_W),
        .NUM_CS (NUM_CS),
        .DIV_W  (DIV_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ready     (ready),
        .data_in   (data_in),
        .cs_sel    (cs_sel),
        .cpol      (cpol),
        .cpha      (cpha),
        .lsb_first (lsb_first),
        .clk_div   (clk_div),
        .done      (done),
        .data_out  (data_out),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .spi_cs_n  (spi_cs_n)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] exp_q[$];
    int                exp_d_q[$];

    // Slave model and per-transfer observations
    bit                loop_en = 1'b1;
    logic [DATA_W-1:0] s_word  = '0;
    bit                s_lsb   = 1'b0;
    bit                s_cpha  = 1'b0;
    logic              s_bit   = 1'b0;
    logic              prev_sclk = 1'b0;
    logic              prev_mosi = 1'b0;
    logic              prev_cs_low = 1'b0;
    int e, tog, mosi_bad, mosi_hi, cs_low_cnt, min_iv, max_iv, last_tog, t_acc;
    int done_cnt = 0;

    always_comb spi_miso = loop_en ? spi_mosi : s_bit;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic slave_bit(input int ev);
        int idx;
        idx = s_cpha ? ((ev == 0) ? 0 : (ev - 1) / 2) : ev / 2;
        if (idx > DATA_W - 1) idx = DATA_W - 1;
        return s_lsb ? s_word[idx] : s_word[DATA_W-1-idx];
    endfunction

    // One clock cycle, observed on the falling clk edge.
    task automatic tick();
        logic cs_low;
        logic fell;
        @(negedge clk);
        cs_low = (spi_cs_n != '1);
        fell   = (prev_sclk === 1'b1) && (spi_sclk === 1'b0);
        if ((spi_mosi !== prev_mosi) && cs_low && prev_cs_low && !fell) mosi_bad++;
        if (spi_sclk !== prev_sclk) begin
            e++;
            tog++;
            if (cyc - last_tog < min_iv) min_iv = cyc - last_tog;
            if (cyc - last_tog > max_iv) max_iv = cyc - last_tog;
            last_tog = cyc;
        end
        if (cs_low) cs_low_cnt++;
        if (cs_low && spi_mosi === 1'b1) mosi_hi++;
        if (done === 1'b1) done_cnt++;
        s_bit       = slave_bit(e);
        prev_sclk   = spi_sclk;
        prev_mosi   = spi_mosi;
        prev_cs_low = cs_low;
    endtask

    task automatic set_cfg(input logic [7:0] d, input logic [1:0] sel, input logic p,
                           input logic h, input logic l, input logic [7:0] div,
                           input logic [7:0] sw, input bit lp);
        data_in = d; cs_sel = sel; cpol = p; cpha = h; lsb_first = l; clk_div = div;
        s_word = sw; s_cpha = h; s_lsb = l; loop_en = lp;
        tick();
        tick();
    endtask

    // Open a transfer accepted at the end of the current cycle.
    task automatic arm(input logic [7:0] expd);
        t_acc = cyc;
        e = 0; tog = 0; mosi_bad = 0; mosi_hi = 0; cs_low_cnt = 0;
        min_iv = 1 << 30; max_iv = 0; last_tog = t_acc + 1;
        prev_sclk = cpol;
        s_bit = slave_bit(0);
        exp_q.push_back(expd);
        exp_d_q.push_back(t_acc + 1 + (2 * DATA_W + 1) * (int'(clk_div) + 1));
    endtask

    task automatic accept(input logic [7:0] expd);
        start = 1'b1;
        arm(expd);
        tick();
    endtask

    task automatic wait_done(input int budget);
        bit got;
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (done === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        chk("done_seen", {31'd0, got}, 32'd1);
        if (got && exp_q.size() > 0) begin
            chk("data_out", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
            chk("done_cycle", cyc, exp_d_q.pop_front());
        end
    endtask

    initial begin
        int d0;
        bit hit;
        rst = 1'b1; start = 1'b0; data_in = '0; cs_sel = '0;
        cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; clk_div = '0;
        tick();
        tick();
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_data_out", {24'd0, data_out}, 32'd0);
        chk("rst_sclk", {31'd0, spi_sclk}, 32'd0);
        chk("rst_mosi", {31'd0, spi_mosi}, 32'd0);
        chk("rst_cs_n", {29'd0, spi_cs_n}, 32'h7);
        rst = 1'b0;

        // Mode 0, H=1, loopback
        set_cfg(8'hA5, 2'd0, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 1'b1);
        accept(8'hA5);
        start = 1'b0;
        chk("m0_ready_low", {31'd0, ready}, 32'd0);
        chk("m0_cs_low", {29'd0, spi_cs_n}, 32'h6);
        chk("m0_sclk_start", {31'd0, spi_sclk}, 32'd0);
        wait_done(100);
        chk("m0_cs_high_at_done", {29'd0, spi_cs_n}, 32'h7);
        chk("m0_ready_at_done", {31'd0, ready}, 32'd1);
        chk("m0_toggles", tog, 16);
        chk("m0_sclk_idle", {31'd0, spi_sclk}, 32'd0);
        chk("m0_cs_low_cycles", cs_low_cnt, 17);

        // Mode 3, H=4, slave returns 0xC3
        set_cfg(8'h3C, 2'd1, 1'b1, 1'b1, 1'b0, 8'd3, 8'hC3, 1'b0);
        accept(8'hC3);
        start = 1'b0;
        chk("m3_sclk_idle_high", {31'd0, spi_sclk}, 32'd1);
        chk("m3_cs_low", {29'd0, spi_cs_n}, 32'h5);
        wait_done(200);
        chk("m3_toggles", tog, 16);
        chk("m3_min_half", min_iv, 4);
        chk("m3_max_half", max_iv, 4);
        chk("m3_mosi_on_fall", mosi_bad, 0);
        chk("m3_cs_low_cycles", cs_low_cnt, 68);

        // Mode 1, LSB first, H=2
        set_cfg(8'h01, 2'd0, 1'b0, 1'b1, 1'b1, 8'd1, 8'h80, 1'b0);
        accept(8'h80);
        start = 1'b0;
        wait_done(100);
        chk("lsb_mosi_hi_cycles", mosi_hi, 6);

        // Back-to-back with start held; second transfer's config changed mid-first
        d0 = done_cnt;
        set_cfg(8'h5A, 2'd2, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 1'b1);
        accept(8'h5A);
        chk("b2b_cs2_low", {29'd0, spi_cs_n}, 32'h3);
        cs_sel = 2'd0; data_in = 8'hC7;
        wait_done(100);
        chk("b2b_gap_all_high", {29'd0, spi_cs_n}, 32'h7);
        arm(8'hC7);
        tick();
        start = 1'b0;
        chk("b2b_cs0_low", {29'd0, spi_cs_n}, 32'h6);
        chk("b2b_ready_low", {31'd0, ready}, 32'd0);
        tick(); tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(100);
        for (int i = 0; i < 30; i++) tick();
        chk("b2b_done_pulses", done_cnt - d0, 2);
        chk("b2b_no_third", cs_low_cnt, 17);

        // Reset at edge 5
        set_cfg(8'hE1, 2'd1, 1'b0, 1'b0, 1'b0, 8'd1, 8'h00, 1'b1);
        accept(8'hE1);
        start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (e == 5) begin
                hit = 1'b1;
                break;
            end
            tick();
        end
        chk("rst_edge5_reached", {31'd0, hit}, 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_cs_n", {29'd0, spi_cs_n}, 32'h7);
        chk("mid_rst_ready", {31'd0, ready}, 32'd1);
        chk("mid_rst_data_out", {24'd0, data_out}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        d0 = done_cnt;
        exp_q.delete();
        exp_d_q.delete();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 40; i++) tick();
        chk("post_rst_no_done", done_cnt - d0, 0);
        set_cfg(8'h3B, 2'd1, 1'b0, 1'b0, 1'b1, 8'd0, 8'h00, 1'b1);
        accept(8'h3B);
        start = 1'b0;
        wait_done(100);

        // Out-of-range chip select
        d0 = done_cnt;
        set_cfg(8'h96, 2'd3, 1'b0, 1'b0, 1'b0, 8'd0, 8'h00, 1'b1);
        accept(8'h96);
        start = 1'b0;
        chk("oor_cs_high", {29'd0, spi_cs_n}, 32'h7);
        chk("oor_ready_low", {31'd0, ready}, 32'd0);
        wait_done(100);
        for (int i = 0; i < 10; i++) tick();
        chk("oor_cs_never_low", cs_low_cnt, 0);
        chk("oor_toggles", tog, 16);
        chk("oor_done_once", done_cnt - d0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
